// File: rtl/core_mc.sv
// core_mc: multi-cycle accumulator-style core. It fetches each instruction from an
// external memory over a req/ack handshake and executes it the cycle after.
// The state sequence is IDLE -> FETCH <-> EXEC -> HALTED.

module core_mc #(
  parameter int unsigned IW  = 8,   // instruction width, IW >= 3 + 2*RFW
  parameter int unsigned IMW = 4,   // pc / instruction-address width
  parameter int unsigned DW  = 8,   // data width, DW >= IMW
  parameter int unsigned RFW = 2,   // register-address width
  parameter int unsigned CW  = 16   // retired-instruction counter width
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           im_req,
  output logic [IMW-1:0] im_addr,
  input  logic           im_ack,
  input  logic [IW-1:0]  im_data,
  output logic           halted,
  output logic           busy,
  output logic [IMW-1:0] pc,
  output logic [CW-1:0]  instret,
  input  logic [RFW-1:0] dbg_addr,
  output logic [DW-1:0]  dbg_data
);

  localparam int unsigned IMMW = IW - 3 - RFW;
  localparam int unsigned NREG = 2 ** RFW;

  localparam logic [2:0] OpAdd  = 3'b000;
  localparam logic [2:0] OpSub  = 3'b001;
  localparam logic [2:0] OpNand = 3'b010;
  localparam logic [2:0] OpMov  = 3'b011;
  localparam logic [2:0] OpLi   = 3'b100;
  localparam logic [2:0] OpAddi = 3'b101;
  localparam logic [2:0] OpBnz  = 3'b110;
  localparam logic [2:0] OpHalt = 3'b111;

  typedef enum logic [1:0] {StIdle, StFetch, StExec, StHalted} state_e;

  state_e          state_q;
  logic [IMW-1:0]  pc_q;
  logic [IW-1:0]   ir_q;
  logic [CW-1:0]   instret_q;
  logic [DW-1:0]   regs_q [NREG];
  logic            im_req_q;
  logic            halted_q;
  logic            busy_q;

  // Instruction fields; imm overlaps the low bits of the rs1 field.
  logic [2:0]      op;
  logic [RFW-1:0]  rd;
  logic [RFW-1:0]  rs1;
  logic [IMMW-1:0] imm;
  logic [DW-1:0]   rd_val;
  logic [DW-1:0]   rs1_val;

  assign op      = ir_q[IW-1 -: 3];
  assign rd      = ir_q[IW-4 -: RFW];
  assign rs1     = ir_q[IW-4-RFW -: RFW];
  assign imm     = ir_q[IMMW-1:0];
  assign rd_val  = regs_q[rd];
  assign rs1_val = regs_q[rs1];

  logic           wr_en;
  logic [DW-1:0]  wr_data;
  logic [IMW-1:0] pc_next;

  // Execute-stage datapath: register write value and next pc for the held instruction.
  always_comb begin
    wr_en   = 1'b1;
    wr_data = '0;
    pc_next = pc_q + IMW'(1);
    case (op)
      OpAdd:   wr_data = rd_val + rs1_val;
      OpSub:   wr_data = rd_val - rs1_val;
      OpNand:  wr_data = ~(rd_val & rs1_val);
      OpMov:   wr_data = rs1_val;
      OpLi:    wr_data = DW'(imm);
      OpAddi:  wr_data = rd_val + DW'($signed(imm));
      OpBnz: begin
        wr_en = 1'b0;
        if (rd_val != '0) pc_next = rs1_val[IMW-1:0];
      end
      OpHalt: begin
        wr_en   = 1'b0;
        pc_next = pc_q;
      end
      default: wr_en = 1'b0;
    endcase
  end

  // Control FSM, architectural state and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      ir_q      <= '0;
      instret_q <= '0;
      im_req_q  <= 1'b0;
      halted_q  <= 1'b0;
      busy_q    <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            pc_q     <= '0;
            state_q  <= StFetch;
            im_req_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        StFetch: begin
          if (im_ack) begin
            ir_q     <= im_data;
            state_q  <= StExec;
            im_req_q <= 1'b0;
          end
        end
        StExec: begin
          instret_q <= instret_q + CW'(1);
          if (op == OpHalt) begin
            state_q  <= StHalted;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
          end else begin
            if (wr_en) regs_q[rd] <= wr_data;
            pc_q     <= pc_next;
            state_q  <= StFetch;
            im_req_q <= 1'b1;
          end
        end
        StHalted: begin
          // Restart keeps registers and instret; only pc is cleared.
          if (start) begin
            pc_q     <= '0;
            state_q  <= StFetch;
            im_req_q <= 1'b1;
            busy_q   <= 1'b1;
            halted_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign im_req   = im_req_q;
  assign im_addr  = pc_q;
  assign pc       = pc_q;
  assign instret  = instret_q;
  assign halted   = halted_q;
  assign busy     = busy_q;
  assign dbg_data = regs_q[dbg_addr];

endmodule
